// File: rtl/hazard_forward_unit_if.sv
// rtl/hazard_forward_unit_if.sv - ID-stage decode in, forwarding/stall control out
interface hazard_forward_unit_if #(
    parameter int RA_W = 5
);
    logic            rf_le_id;
    logic            l_id;
    logic [RA_W-1:0] ird_id;
    logic [RA_W-1:0] ra_id;
    logic [RA_W-1:0] rb_id;
    logic            use_ra;
    logic            use_rb;
    logic            j_ex;
    logic [1:0]      fw_a_sel;
    logic [1:0]      fw_b_sel;
    logic            nop_sel;
    logic            pc_le;
    logic            ifid_le;
    logic            ifid_clr;

    // master: pipeline/CU side; slave: the hazard unit
    modport master (
        output rf_le_id, l_id, ird_id, ra_id, rb_id, use_ra, use_rb, j_ex,
        input  fw_a_sel, fw_b_sel, nop_sel, pc_le, ifid_le, ifid_clr
    );

    modport slave (
        input  rf_le_id, l_id, ird_id, ra_id, rb_id, use_ra, use_rb, j_ex,
        output fw_a_sel, fw_b_sel, nop_sel, pc_le, ifid_le, ifid_clr
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - operand forwarding, load-use stall and jump squash control
// Tracks its own EX/MEM/WB shadow of destination/write-enable/load so only ID decode is needed.
module hazard_forward_unit #(
    parameter int RA_W       = 5,
    parameter int LU_STALL   = 1,
    parameter int DELAY_SLOT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_forward_unit_if.slave hif
);

    logic            v_ex, le_ex, ld_ex;
    logic [RA_W-1:0] rd_ex;
    logic            v_mem, le_mem, ld_mem;
    logic [RA_W-1:0] rd_mem;
    logic            v_wb, le_wb;
    logic [RA_W-1:0] rd_wb;

    logic [1:0] scnt;
    logic       haz_ex, haz_mem, hazard, stall;
    logic [1:0] fw_a, fw_b;
    logic [1:0] fw_a_out, fw_b_out;
    logic       nop, pc_le, ifid_le, ifid_clr;

    function automatic logic [1:0] fwd_sel(
        input logic            use_s,
        input logic [RA_W-1:0] src,
        input logic            ve, input logic le_e, input logic [RA_W-1:0] rde,
        input logic            vm, input logic le_m, input logic [RA_W-1:0] rdm,
        input logic            vw, input logic le_w, input logic [RA_W-1:0] rdw
    );
        // GR0 is hardwired zero and never forwarded
        if (!use_s || src == '0)               return 2'b00;
        else if (ve && le_e && rde == src)     return 2'b01;
        else if (vm && le_m && rdm == src)     return 2'b10;
        else if (vw && le_w && rdw == src)     return 2'b11;
        else                                   return 2'b00;
    endfunction

    function automatic logic ld_match(
        input logic            ld,
        input logic            le,
        input logic [RA_W-1:0] rd,
        input logic            ua,
        input logic            ub,
        input logic [RA_W-1:0] ra,
        input logic [RA_W-1:0] rb
    );
        return ld && le && (rd != '0) && ((ua && ra == rd) || (ub && rb == rd));
    endfunction

    always_comb begin
        fw_a = fwd_sel(hif.use_ra, hif.ra_id,
                       v_ex, le_ex, rd_ex, v_mem, le_mem, rd_mem, v_wb, le_wb, rd_wb);
        fw_b = fwd_sel(hif.use_rb, hif.rb_id,
                       v_ex, le_ex, rd_ex, v_mem, le_mem, rd_mem, v_wb, le_wb, rd_wb);
    end

    always_comb begin
        haz_ex  = ld_match(ld_ex, le_ex, rd_ex, hif.use_ra, hif.use_rb, hif.ra_id, hif.rb_id);
        haz_mem = (LU_STALL == 2) &&
                  ld_match(ld_mem, le_mem, rd_mem, hif.use_ra, hif.use_rb, hif.ra_id, hif.rb_id);
        hazard  = haz_ex || haz_mem;
        // a taken jump squashes the stalled instruction anyway, so it overrides the stall
        stall   = (hazard || scnt != 2'd0) && !hif.j_ex;
    end

    always_comb begin
        fw_a_out = 2'b00;
        fw_b_out = 2'b00;
        nop      = 1'b0;
        pc_le    = 1'b1;
        ifid_le  = 1'b1;
        ifid_clr = 1'b0;
        if (reset) begin
            nop      = 1'b1;
            pc_le    = 1'b0;
            ifid_le  = 1'b0;
            ifid_clr = 1'b1;
        end else begin
            fw_a_out = fw_a;
            fw_b_out = fw_b;
            if (hif.j_ex) begin
                ifid_clr = 1'b1;
                nop      = (DELAY_SLOT == 0);
            end else if (stall) begin
                nop     = 1'b1;
                pc_le   = 1'b0;
                ifid_le = 1'b0;
            end
        end
    end

    assign hif.fw_a_sel = fw_a_out;
    assign hif.fw_b_sel = fw_b_out;
    assign hif.nop_sel  = nop;
    assign hif.pc_le    = pc_le;
    assign hif.ifid_le  = ifid_le;
    assign hif.ifid_clr = ifid_clr;

    always_ff @(posedge clk) begin
        if (reset) begin
            v_ex   <= 1'b0;
            le_ex  <= 1'b0;
            ld_ex  <= 1'b0;
            rd_ex  <= '0;
            v_mem  <= 1'b0;
            le_mem <= 1'b0;
            ld_mem <= 1'b0;
            rd_mem <= '0;
            v_wb   <= 1'b0;
            le_wb  <= 1'b0;
            rd_wb  <= '0;
            scnt   <= 2'd0;
        end else begin
            // a bubble enters EX with no write and no load
            v_ex   <= !nop;
            le_ex  <= hif.rf_le_id && !nop;
            ld_ex  <= hif.l_id && !nop;
            rd_ex  <= hif.ird_id;
            v_mem  <= v_ex;
            le_mem <= le_ex;
            ld_mem <= ld_ex;
            rd_mem <= rd_ex;
            v_wb   <= v_mem;
            le_wb  <= le_mem;
            rd_wb  <= rd_mem;

            // reload only from idle so an ongoing countdown is not re-armed by the same load
            if (hif.j_ex)
                scnt <= 2'd0;
            else if (scnt != 2'd0)
                scnt <= scnt - 2'd1;
            else if (hazard)
                scnt <= 2'(LU_STALL - 1);
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed bench; dut1 LU_STALL=1/DELAY_SLOT=1, dut2 LU_STALL=2/DELAY_SLOT=0
module tb_hazard_forward_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_forward_unit_if #(.RA_W(5)) hif1 ();
    hazard_forward_unit_if #(.RA_W(5)) hif2 ();

    hazard_forward_unit #(.RA_W(5), .LU_STALL(1), .DELAY_SLOT(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .hif   (hif1)
    );

    hazard_forward_unit #(.RA_W(5), .LU_STALL(2), .DELAY_SLOT(0)) dut2 (
        .clk   (clk),
        .reset (reset),
        .hif   (hif2)
    );

    // {nop_sel, pc_le, ifid_le, ifid_clr}
    localparam logic [3:0] C_IDLE = 4'b0110;
    localparam logic [3:0] C_RST  = 4'b1001;
    localparam logic [3:0] C_STL  = 4'b1000;
    localparam logic [3:0] C_JMP  = 4'b0111;
    localparam logic [3:0] C_JMPN = 4'b1111;

    int checks   = 0;
    int failures = 0;

    logic [7:0] o1, o2;
    assign o1 = {hif1.fw_a_sel, hif1.fw_b_sel, hif1.nop_sel, hif1.pc_le, hif1.ifid_le, hif1.ifid_clr};
    assign o2 = {hif2.fw_a_sel, hif2.fw_b_sel, hif2.nop_sel, hif2.pc_le, hif2.ifid_le, hif2.ifid_clr};

    task automatic drive(input logic le, input logic l, input logic [4:0] rd,
                         input logic [4:0] ra, input logic [4:0] rb,
                         input logic ua, input logic ub, input logic j);
        hif1.rf_le_id = le; hif1.l_id = l; hif1.ird_id = rd;
        hif1.ra_id = ra; hif1.rb_id = rb; hif1.use_ra = ua; hif1.use_rb = ub; hif1.j_ex = j;
        hif2.rf_le_id = le; hif2.l_id = l; hif2.ird_id = rd;
        hif2.ra_id = ra; hif2.rb_id = rb; hif2.use_ra = ua; hif2.use_rb = ub; hif2.j_ex = j;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // check both DUTs mid-cycle, then advance to just after the next rising edge
    task automatic step(input string tag, input logic [7:0] e1, input logic [7:0] e2);
        @(negedge clk);
        chk({tag, "/d1"}, o1, e1);
        chk({tag, "/d2"}, o2, e2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        @(posedge clk);
        #1;
        step("reset", {4'b0000, C_RST}, {4'b0000, C_RST});
        reset = 1'b0;

        // EX -> MEM -> WB forwarding of r3
        drive(1, 0, 5'd3, 5'd1, 5'd2, 1, 1, 0);
        step("add_r3", {4'b0000, C_IDLE}, {4'b0000, C_IDLE});
        drive(0, 0, 5'd4, 5'd3, 5'd0, 1, 0, 0);
        step("fwd_ex", {2'b01, 2'b00, C_IDLE}, {2'b01, 2'b00, C_IDLE});
        step("fwd_mem", {2'b10, 2'b00, C_IDLE}, {2'b10, 2'b00, C_IDLE});
        step("fwd_wb", {2'b11, 2'b00, C_IDLE}, {2'b11, 2'b00, C_IDLE});

        // r5 in all three stages: EX wins
        drive(1, 0, 5'd5, 5'd5, 5'd5, 1, 1, 0);
        step("prio_0", {4'b0000, C_IDLE}, {4'b0000, C_IDLE});
        step("prio_1", {4'b0101, C_IDLE}, {4'b0101, C_IDLE});
        step("prio_2", {4'b0101, C_IDLE}, {4'b0101, C_IDLE});
        step("prio_3", {4'b0101, C_IDLE}, {4'b0101, C_IDLE});

        // GR0 never forwarded
        drive(1, 0, 5'd0, 5'd0, 5'd5, 1, 1, 0);
        step("gr0_src", {4'b0001, C_IDLE}, {4'b0001, C_IDLE});
        drive(0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0);
        step("gr0_ex", {4'b0000, C_IDLE}, {4'b0000, C_IDLE});

        // load-use on rb=7
        drive(1, 1, 5'd7, 5'd0, 5'd0, 0, 0, 0);
        step("ldw_r7", {4'b0000, C_IDLE}, {4'b0000, C_IDLE});
        drive(0, 0, 5'd0, 5'd0, 5'd7, 0, 1, 0);
        step("lu_stall1", {4'b0001, C_STL}, {4'b0001, C_STL});
        step("lu_stall2", {4'b0010, C_IDLE}, {4'b0010, C_STL});
        step("lu_done", {4'b0011, C_IDLE}, {4'b0011, C_IDLE});

        // taken jump: delay slot kept on dut1, nulled on dut2
        drive(1, 0, 5'd9, 5'd0, 5'd0, 0, 0, 1);
        step("jump", {4'b0000, C_JMP}, {4'b0000, C_JMPN});
        drive(0, 0, 5'd0, 5'd9, 5'd0, 1, 0, 0);
        step("slot_fwd", {4'b0100, C_IDLE}, {4'b0000, C_IDLE});

        // jump during the second stall cycle ends the stall at once
        drive(1, 1, 5'd6, 5'd0, 5'd0, 0, 0, 0);
        step("ldw_r6", {4'b0000, C_IDLE}, {4'b0000, C_IDLE});
        drive(0, 0, 5'd0, 5'd6, 5'd0, 1, 0, 0);
        step("js_stall", {4'b0100, C_STL}, {4'b0100, C_STL});
        drive(0, 0, 5'd0, 5'd6, 5'd0, 1, 0, 1);
        step("js_jump", {4'b1000, C_JMP}, {4'b1000, C_JMPN});
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        step("js_after", {4'b0000, C_IDLE}, {4'b0000, C_IDLE});

        // reset in the middle of a stall
        drive(1, 1, 5'd8, 5'd0, 5'd0, 0, 0, 0);
        step("ldw_r8", {4'b0000, C_IDLE}, {4'b0000, C_IDLE});
        drive(0, 0, 5'd0, 5'd0, 5'd8, 0, 1, 0);
        step("rs_stall", {4'b0001, C_STL}, {4'b0001, C_STL});
        reset = 1'b1;
        step("rs_reset", {4'b0000, C_RST}, {4'b0000, C_RST});
        reset = 1'b0;
        step("rs_after", {4'b0000, C_IDLE}, {4'b0000, C_IDLE});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
